spram_bank_power_ctrl: RTL
==========================

# spram_bank_power_ctrl

Per-bank power-state sequencer for the two-bank cascaded SPRAM instruction/data memory. It sits between the single memory requester and the two memory banks. It generates each bank's chip_sel, standby, sleep and poweroff controls, and stalls the requester through `req_ready` while a bank is woken. Idle banks are demoted automatically: ACTIVE → STANDBY → SLEEP. Software can force a bank fully off.

## Interface
Parameters:
- `IDLE_STANDBY`, default 16: consecutive idle cycles before a bank enters STANDBY. Must be ≥1.
- `IDLE_SLEEP`, default 256: consecutive idle cycles before a bank enters SLEEP. Must be > `IDLE_STANDBY`.
- `WAKE_CYCLES`, default 4: cycles a bank spends in WAKE when leaving SLEEP or OFF. Must be ≥1.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: requester has an access this cycle.
- `req_addr` in 15: access address. Bit 14 selects the bank.
- `req_ready` out 1: access accepted this cycle. Combinational.
- `force_off` in 2: per-bank software power-off request. Level-sensitive.
- `bank_chip_sel` out 2: per-bank chip select. Combinational.
- `bank_standby` out 2: per-bank standby control. Registered.
- `bank_sleep` out 2: per-bank sleep control. Registered.
- `bank_poweroff` out 2: per-bank power-off control. 1 = powered off. Registered.
- `bank_state` out 6: `{bank1[2:0], bank0[2:0]}`. Encoding: ACTIVE=0, STANDBY=1, SLEEP=2, WAKE=3, OFF=4.

## Operation
- Target bank: `b = req_addr[14]`.
- Accept condition: `req_ready = req_valid & (state[b]==ACTIVE) & ~force_off[b]`.
- `bank_chip_sel[b] = req_ready`. The other bit is 0.
- Each bank has an independent FSM and a saturating idle counter, `$clog2(IDLE_SLEEP+1)` bits wide.

Per-bank FSM, evaluated in priority order each cycle:
- **Any state**: `force_off[i]=1` → OFF. The counter clears.
- **ACTIVE**:
  - Accepted access to bank i → counter clears.
  - Otherwise the counter increments.
  - Counter reaching `IDLE_STANDBY` → STANDBY.
- **STANDBY**:
  - `req_valid` targeting bank i → ACTIVE next cycle. The counter clears. The access is not accepted this cycle.
  - Otherwise the counter increments.
  - Counter reaching `IDLE_SLEEP` → SLEEP.
- **SLEEP**: `req_valid` targeting bank i → WAKE, loading the wake counter with `WAKE_CYCLES`.
- **WAKE**:
  - The wake counter decrements. At 1 → ACTIVE, and the idle counter clears.
  - WAKE always completes, even if `req_valid` drops.
- **OFF**:
  - When `force_off[i]` falls → WAKE, with `WAKE_CYCLES`.
  - Bank contents are undefined after OFF. The requester is responsible for reloading them.

Output decode, registered from the next state:
- STANDBY → `standby=1`.
- SLEEP → `sleep=1`.
- OFF → `poweroff=1`.
- ACTIVE and WAKE → all three 0.
- At most one of `standby`/`sleep`/`poweroff` is 1 per bank.

Other rules:
- The bank not addressed continues its own idle sequencing regardless of traffic to the other bank.
- An access accepted in the same cycle the counter would reach `IDLE_STANDBY`: the access wins. The bank stays ACTIVE and the counter clears.

## Timing
- Reset values:
  - Both banks ACTIVE, all counters 0.
  - `bank_standby`, `bank_sleep`, `bank_poweroff` = 0.
  - `bank_state` = 0.
  - `req_ready` and `bank_chip_sel` follow their combinational equations (0 when `req_valid=0`).
- Access latency:
  - ACTIVE bank: 0 extra cycles (ready the same cycle).
  - STANDBY bank: 1 stall cycle.
  - SLEEP bank: `WAKE_CYCLES+1` stall cycles.
  - OFF bank: ready no earlier than `WAKE_CYCLES+1` cycles after `force_off` falls.
- The requester holds `req_valid` and `req_addr` stable until `req_ready`. The controller does not register a pending request.
- Reset asserted mid-WAKE or in OFF: both banks return to ACTIVE on the next edge, and outputs clear. Reset overrides `force_off` for that cycle; `force_off` still high after reset drives OFF one cycle later.
- Idle counters saturate at `IDLE_SLEEP` and never wrap.

## Test plan
- Reset, then `req_valid=1`, `addr=0x0010` each cycle → `req_ready=1` every cycle, `chip_sel=01`, bank0 stays ACTIVE. Bank1 reaches STANDBY after 16 cycles and SLEEP after 256, with `bank_sleep=10`.
- Bank0 idle 20 cycles (STANDBY), then request `addr=0x0004` → `req_ready` low 1 cycle, high the next, `bank_standby[0]` falls on that edge.
- Bank1 in SLEEP, request `addr=0x4000` with `WAKE_CYCLES=4` → `bank_state` bank1 goes 2→3 for 4 cycles →0, `req_ready` rises on cycle 5.
- Assert `force_off=01` while `req_valid` targets bank0 → `req_ready=0`, `bank_poweroff[0]=1` next edge. Deassert → WAKE 4 cycles, then ready.
- Bank0 counter at 15 and access accepted that cycle → stays ACTIVE, counter 0, `bank_standby[0]` never asserts.
- Assert `reset` during bank1 WAKE cycle 2 → next edge: all states 0, all power outputs 0.

Source files
------------

// File: rtl/spram_bank_power_ctrl.sv
// Power-state sequencer for the two SPRAM banks: idle demotion ACTIVE->STANDBY->SLEEP,
// wake sequencing, software power-off, and requester stall via req_ready.
module spram_bank_power_ctrl #(
  parameter int IDLE_STANDBY = 16,
  parameter int IDLE_SLEEP   = 256,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [14:0] req_addr,
  output logic        req_ready,
  input  logic [1:0]  force_off,
  output logic [1:0]  bank_chip_sel,
  output logic [1:0]  bank_standby,
  output logic [1:0]  bank_sleep,
  output logic [1:0]  bank_poweroff,
  output logic [5:0]  bank_state
);

  localparam int CW = $clog2(IDLE_SLEEP + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [CW-1:0] STANDBY_AT = CW'(IDLE_STANDBY);
  localparam logic [CW-1:0] SLEEP_AT   = CW'(IDLE_SLEEP);
  localparam logic [WW-1:0] WAKE_LOAD  = WW'(WAKE_CYCLES);

  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    STANDBY = 3'd1,
    SLEEP   = 3'd2,
    WAKE    = 3'd3,
    OFF     = 3'd4
  } pstate_t;

  pstate_t         state_q [2];
  pstate_t         state_d [2];
  logic [CW-1:0]   idle_q  [2];
  logic [CW-1:0]   idle_d  [2];
  logic [WW-1:0]   wake_q  [2];
  logic [WW-1:0]   wake_d  [2];
  logic            target;
  logic [1:0]      hit;
  logic            unused_addr;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == SLEEP_AT) ? c : c + 1'b1;
  endfunction

  assign target      = req_addr[14];
  assign unused_addr = ^req_addr[13:0];
  assign hit         = req_valid ? (target ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    req_ready     = req_valid & (state_q[target] == ACTIVE) & ~force_off[target];
    bank_chip_sel = target ? {req_ready, 1'b0} : {1'b0, req_ready};
  end

  assign bank_state = {state_q[1], state_q[0]};

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      wake_d[i]  = wake_q[i];
      if (force_off[i]) begin
        state_d[i] = OFF;
        idle_d[i]  = '0;
      end else begin
        case (state_q[i])
          ACTIVE: begin
            // An access landing on the would-be STANDBY cycle keeps the bank awake.
            if (bank_chip_sel[i]) begin
              idle_d[i] = '0;
            end else begin
              idle_d[i] = sat_inc(idle_q[i]);
              if (idle_d[i] == STANDBY_AT) state_d[i] = STANDBY;
            end
          end
          STANDBY: begin
            if (hit[i]) begin
              state_d[i] = ACTIVE;
              idle_d[i]  = '0;
            end else begin
              idle_d[i] = sat_inc(idle_q[i]);
              if (idle_d[i] == SLEEP_AT) state_d[i] = SLEEP;
            end
          end
          SLEEP: begin
            if (hit[i]) begin
              state_d[i] = WAKE;
              wake_d[i]  = WAKE_LOAD;
            end
          end
          WAKE: begin
            if (wake_q[i] == WW'(1)) begin
              state_d[i] = ACTIVE;
              idle_d[i]  = '0;
              wake_d[i]  = '0;
            end else begin
              wake_d[i] = wake_q[i] - 1'b1;
            end
          end
          OFF: begin
            state_d[i] = WAKE;
            wake_d[i]  = WAKE_LOAD;
          end
          default: begin
            state_d[i] = ACTIVE;
            idle_d[i]  = '0;
            wake_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= ACTIVE;
        idle_q[i]  <= '0;
        wake_q[i]  <= '0;
      end
      bank_standby  <= '0;
      bank_sleep    <= '0;
      bank_poweroff <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i]       <= state_d[i];
        idle_q[i]        <= idle_d[i];
        wake_q[i]        <= wake_d[i];
        bank_standby[i]  <= (state_d[i] == STANDBY);
        bank_sleep[i]    <= (state_d[i] == SLEEP);
        bank_poweroff[i] <= (state_d[i] == OFF);
      end
    end
  end

endmodule
